rr_arb8: RTL
============

# rr_arb8

Eight-way round-robin arbiter that shares one downstream resource (bus, UART TX, display driver) between eight requesters on the board. It uses a rotating priority-encoder selection and keeps a grant registered until the owner drops its request or its hold budget expires. Priority then rotates so that no requester is starved. It sits between the user request lines and the shared datapath's select mux.

## Interface

**Parameters**
- `MAX_HOLD`, default 16: maximum consecutive cycles one owner may hold the grant while others wait. Legal range 1..255.

**Ports**
- `clk`: input, 1 bit. Single system clock, rising edge.
- `rst`: input, 1 bit. Asynchronous, active-high reset.
- `req`: input, 8 bits. Request lines. `req[i]` high means requester i wants the resource. Level-sensitive.
- `grant`: output, 8 bits. One-hot grant, registered. All zero when no owner.
- `grant_id`: output, 3 bits. Binary index of the owner, registered.
- `grant_valid`: output, 1 bit. High when `grant` is non-zero.

## Operation

**State machine:** IDLE and BUSY.

**Reset (asynchronous):**
- State goes to IDLE.
- `grant` = 8'h00, `grant_id` = 3'd0, `grant_valid` = 0.
- `last` = 3'd7, so requester 0 has top priority after reset.
- `hold_cnt` = 0.

**Selection (combinational, `pick`):**
- Search `req` starting at index `last`+1 and wrap modulo 8, in the order `last`+1, `last`+2, …, `last`.
- The first set bit wins.
- If `req` == 0, nothing is picked.

**IDLE:**
- If any `req` bit is set, register `grant`, `grant_id` and `grant_valid` = 1 for the picked index, set `last` = picked, clear `hold_cnt`, and go to BUSY.
- Otherwise stay in IDLE.

**BUSY, owner `o` = `grant_id`:**
- **Owner release** (`req[o]` == 0): if other requests are pending, re-arbitrate in the same cycle and register the new owner with no idle bubble. If none are pending, clear the grant and go to IDLE.
- **Hold expiry** (`req[o]` == 1 and `hold_cnt` == `MAX_HOLD`−1):
  - If any other `req` bit is set, grant the next owner via `pick`. The owner `o` is automatically lowest priority because `last` = o.
  - If no other request is pending, keep `o`, reset `hold_cnt` to 0 and stay in BUSY.
- **Otherwise:** keep the grant and increment `hold_cnt`.

**Width and arithmetic rules:**
- `hold_cnt` is 8 bits. It is incremented only in BUSY and never exceeds `MAX_HOLD`−1.
- Index arithmetic is 3-bit, so wrap 7→0 is implicit.
- `grant` always equals one-hot(`grant_id`) when `grant_valid` = 1, and 0 otherwise.

**Boundary conditions:**
- All eight requesting at once: grants rotate 0,1,…,7,0… as each owner releases or expires.
- A single requester holding forever: the grant is never removed.
- A request glitch that arrives and drops before the next edge is not seen.
- Reset mid-grant: the grant drops immediately (asynchronously) and arbitration restarts from requester 0.

## Timing

- **Grant latency:** if `req` is first seen high at edge k while in IDLE, `grant` is valid after edge k. Outputs are registered, so one cycle from request to grant.
- **Handover latency:** an owner that drops `req` before edge k loses the grant at edge k. The new owner's grant appears at the same edge, so there is zero dead cycles.
- **Maximum tenure:** `MAX_HOLD` cycles while others wait.
- **Worst-case wait** for any requester: 7×`MAX_HOLD` cycles.
- No combinational path from `req` to any output.

## Structure

**Shared package `arb_pkg`:**
- `NUM_REQ` = 8 and `ID_W` = 3.
- State encoding: `ST_IDLE` = 1'b0, `ST_BUSY` = 1'b1.

**Sub-module `rr_pick8`** (combinational):
- Inputs: `req`[7:0] and `last`[2:0].
- Outputs: `pick_id`[2:0] and `pick_valid`.
- Implementation: rotate `req` right by `last`+1, apply a fixed lowest-index-first priority encoder, then add `last`+1 back modulo 8.

**Top-level `rr_arb8`:** holds the FSM, `hold_cnt`, `last` and the output registers.

## Test plan

- **Reset default:** assert `rst` mid-stream with `req` = 8'hFF → all outputs 0 at once. After release, the first grant is `grant_id` = 0 (`grant` = 8'h01) one cycle later.
- **Single request:** `req` = 8'h20 held → `grant` = 8'h20, `grant_id` = 5 after 1 cycle. After `MAX_HOLD` = 16 cycles with no other requester, the grant is still 8'h20.
- **Rotation:** `req` = 8'hFF, each owner drops its bit for exactly the cycle after it is granted → grants 0,1,2,…,7,0 on consecutive cycles with no gaps.
- **Hold expiry:** `MAX_HOLD` = 4, `req` = 8'h03 held constant → `grant` alternates 8'h01 ×4 cycles, 8'h02 ×4 cycles, repeating.
- **Wrap and fairness:** with `last` = 6, `req` = 8'h41 (bits 6 and 0) → the next grant is 0, not 6.
- **Release to empty:** the sole owner drops `req` → `grant_valid` = 0 at the next edge and the FSM is in IDLE. A new `req` = 8'h80 one cycle later gives `grant` = 8'h80.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the eight-way round-robin arbiter: sizes, FSM encoding
// and a one-hot helper.
package arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int ID_W    = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    logic [NUM_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Rotating priority encoder: the search starts one past the last owner and wraps,
// so the last owner is always the lowest priority.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [ID_W-1:0]    pick_id,
  output logic               pick_valid
);

  logic [ID_W-1:0]      w_start;
  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [ID_W-1:0]      w_off;

  // 3-bit arithmetic makes last=7 start the search at index 0.
  assign w_start = last + 3'd1;
  assign w_dbl   = {req, req} >> w_start;
  assign w_rot   = w_dbl[NUM_REQ-1:0];

  // NOTE: every always_comb output gets a default before any branch; without it an
  // unassigned path would infer a latch.
  always_comb begin
    w_off = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (w_rot[j]) w_off = ID_W'(j);
    end
  end

  assign pick_id    = w_off + w_start;
  assign pick_valid = |req;

endmodule

// File: rtl/rr_arb8.sv
// Eight-way round-robin arbiter with registered one-hot grant, release-driven
// handover and a per-owner hold budget.
module rr_arb8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_valid
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t             r_state, w_state_nxt;
  logic [ID_W-1:0]    r_last, w_last_nxt;
  logic [7:0]         r_hold_cnt, w_hold_nxt;
  logic [NUM_REQ-1:0] r_grant;
  logic [ID_W-1:0]    r_grant_id, w_id_nxt;
  logic               r_grant_valid, w_valid_nxt;

  logic [ID_W-1:0]    w_pick_id;
  logic               w_pick_valid;
  logic               w_others;
  logic               w_take;
  logic               w_drop;

  rr_pick8 u_pick (
    .req        (req),
    .last       (r_last),
    .pick_id    (w_pick_id),
    .pick_valid (w_pick_valid)
  );

  assign w_others = |(req & ~onehot(r_grant_id));

  always_comb begin
    w_take = 1'b0;
    w_drop = 1'b0;
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_hold_nxt  = r_hold_cnt;
    w_id_nxt    = r_grant_id;
    w_valid_nxt = r_grant_valid;

    case (r_state)
      ST_IDLE: w_take = w_pick_valid;
      ST_BUSY: begin
        if (!req[r_grant_id]) begin
          w_take = w_pick_valid;
          w_drop = !w_pick_valid;
        end else if (r_hold_cnt == HOLD_LAST) begin
          // last == owner here, so the picker already ranks the owner last.
          w_take     = w_others;
          w_hold_nxt = 8'd0;
        end else begin
          w_hold_nxt = r_hold_cnt + 8'd1;
        end
      end
    endcase

    if (w_take) begin
      w_state_nxt = ST_BUSY;
      w_id_nxt    = w_pick_id;
      w_valid_nxt = 1'b1;
      w_last_nxt  = w_pick_id;
      w_hold_nxt  = 8'd0;
    end else if (w_drop) begin
      w_state_nxt = ST_IDLE;
      w_id_nxt    = '0;
      w_valid_nxt = 1'b0;
      w_hold_nxt  = 8'd0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_last        <= 3'd7;
      r_hold_cnt    <= 8'd0;
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_last        <= w_last_nxt;
      r_hold_cnt    <= w_hold_nxt;
      r_grant       <= w_valid_nxt ? onehot(w_id_nxt) : '0;
      r_grant_id    <= w_id_nxt;
      r_grant_valid <= w_valid_nxt;
    end
  end

  assign grant       = r_grant;
  assign grant_id    = r_grant_id;
  assign grant_valid = r_grant_valid;

endmodule
